// File: rtl/mem_host_arb_if.sv
// Requester/host bundle for mem_host_arb. The arbiter sits on the slave modport.
// The master modport is the environment side: the two requesters plus the host memory port.
interface mem_host_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic [1:0]        cpu_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rd_valid;
  logic              cpu_done;

  logic [1:0]        fpu_op;
  logic [ADDR_W-1:0] fpu_addr;
  logic [DATA_W-1:0] fpu_wdata;
  logic [DATA_W-1:0] fpu_rdata;
  logic              fpu_rd_valid;
  logic              fpu_done;

  logic [1:0]        op_host;
  logic [ADDR_W-1:0] AddrOut_host;
  logic [DATA_W-1:0] DataOut_host;
  logic [DATA_W-1:0] DataIn_host;
  logic              tx_done_host;
  logic              rd_valid_host;

  logic              grant_cpu;
  logic              grant_fpu;

  modport slave (
    input  cpu_op, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rd_valid, cpu_done,
    input  fpu_op, fpu_addr, fpu_wdata,
    output fpu_rdata, fpu_rd_valid, fpu_done,
    output op_host, AddrOut_host, DataOut_host,
    input  DataIn_host, tx_done_host, rd_valid_host,
    output grant_cpu, grant_fpu
  );

  modport master (
    output cpu_op, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rd_valid, cpu_done,
    output fpu_op, fpu_addr, fpu_wdata,
    input  fpu_rdata, fpu_rd_valid, fpu_done,
    input  op_host, AddrOut_host, DataOut_host,
    output DataIn_host, tx_done_host, rd_valid_host,
    input  grant_cpu, grant_fpu
  );
endinterface

// File: rtl/mem_host_arb.sv
// Two-requester (CPU/FPU) arbiter onto one host memory port; grant one cycle after request, held until tx_done_host.
// Ties go to CPU; define MEM_ARB_RR_EN to alternate ties using a last_grant register instead.
module mem_host_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
) (
  input  logic          clk,
  input  logic          rst,
  mem_host_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_FPU = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic cpu_req;
  logic fpu_req;
  logic pick_cpu;
  logic in_cpu;
  logic in_fpu;

  assign cpu_req = (bus.cpu_op == OP_READ) || (bus.cpu_op == OP_WRITE);
  assign fpu_req = (bus.fpu_op == OP_READ) || (bus.fpu_op == OP_WRITE);

`ifdef MEM_ARB_RR_EN
  // 1 = FPU owned the most recent grant; reset value lets CPU win the first tie.
  logic last_fpu_q, last_fpu_d;

  assign pick_cpu = cpu_req && (!fpu_req || last_fpu_q);
`else
  assign pick_cpu = cpu_req;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_ARB_RR_EN
    last_fpu_d = last_fpu_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_cpu) begin
          state_d = GNT_CPU;
          op_d    = bus.cpu_op;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
`ifdef MEM_ARB_RR_EN
          last_fpu_d = 1'b0;
`endif
        end else if (fpu_req) begin
          state_d = GNT_FPU;
          op_d    = bus.fpu_op;
          addr_d  = bus.fpu_addr;
          wdata_d = bus.fpu_wdata;
`ifdef MEM_ARB_RR_EN
          last_fpu_d = 1'b1;
`endif
        end
      end
      GNT_CPU, GNT_FPU: begin
        if (bus.tx_done_host) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_fpu_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_ARB_RR_EN
      last_fpu_q <= last_fpu_d;
`endif
    end
  end

  // Grant-qualified strobes are also masked by rst so an aborted grant never emits done.
  assign in_cpu = (state_q == GNT_CPU) && !rst;
  assign in_fpu = (state_q == GNT_FPU) && !rst;

  assign bus.grant_cpu    = in_cpu;
  assign bus.grant_fpu    = in_fpu;
  assign bus.op_host      = (in_cpu || in_fpu) ? op_q : OP_NOP;
  assign bus.AddrOut_host = addr_q;
  assign bus.DataOut_host = wdata_q;

  assign bus.cpu_rd_valid = in_cpu && bus.rd_valid_host;
  assign bus.fpu_rd_valid = in_fpu && bus.rd_valid_host;
  assign bus.cpu_done     = in_cpu && bus.tx_done_host;
  assign bus.fpu_done     = in_fpu && bus.tx_done_host;

  assign bus.cpu_rdata = bus.DataIn_host;
  assign bus.fpu_rdata = bus.DataIn_host;

endmodule

// File: tb/tb_mem_host_arb.sv
// Directed bench for mem_host_arb: reset, single-requester read/write, ignored IDLE strobes,
// reserved opcode, address stability, tie arbitration and reset mid-grant.
module tb_mem_host_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_host_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_host_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [DATA_W-1:0] pat_a5;
  logic [DATA_W-1:0] ones;
  logic              exp_cpu;

  initial begin
    pat_a5 = {(DATA_W/8){8'hA5}};
    ones   = '1;
    bus.cpu_op = 2'b00; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.fpu_op = 2'b00; bus.fpu_addr = '0; bus.fpu_wdata = '0;
    bus.DataIn_host = '0; bus.tx_done_host = 1'b0; bus.rd_valid_host = 1'b0;

    tick(); tick();
    chk("rst_grant_cpu", bus.grant_cpu, 1'b0);
    chk("rst_grant_fpu", bus.grant_fpu, 1'b0);
    chk("rst_op_host", bus.op_host, 2'b00);
    chk("rst_addr", bus.AddrOut_host, '0);
    chk("rst_data", bus.DataOut_host, '0);
    rst = 1'b0;

    // CPU read of 0x40 alone
    tick();
    bus.cpu_op = 2'b01; bus.cpu_addr = 32'h0000_0040;
    settle();
    chk("rd_idle_no_grant", bus.grant_cpu, 1'b0);
    chk("rd_idle_op_host", bus.op_host, 2'b00);
    tick();
    chk("rd_grant_cpu", bus.grant_cpu, 1'b1);
    chk("rd_grant_fpu", bus.grant_fpu, 1'b0);
    chk("rd_op_host", bus.op_host, 2'b01);
    chk("rd_addr", bus.AddrOut_host, 32'h40);
    chk("rd_no_done_yet", bus.cpu_done, 1'b0);
    // Requester address change mid-grant must not reach the host
    bus.cpu_addr = 32'h0000_0080;
    tick();
    chk("addr_held_0x40", bus.AddrOut_host, 32'h40);
    bus.tx_done_host = 1'b1; bus.rd_valid_host = 1'b1; bus.DataIn_host = pat_a5;
    settle();
    chk("rd_cpu_rd_valid", bus.cpu_rd_valid, 1'b1);
    chk("rd_cpu_done", bus.cpu_done, 1'b1);
    chk("rd_fpu_rd_valid", bus.fpu_rd_valid, 1'b0);
    chk("rd_fpu_done", bus.fpu_done, 1'b0);
    chk("rd_cpu_rdata", bus.cpu_rdata, pat_a5);
    chk("rd_fpu_rdata", bus.fpu_rdata, pat_a5);
    chk("rd_addr_at_done", bus.AddrOut_host, 32'h40);
    tick();
    bus.cpu_op = 2'b00;
    settle();
    chk("rd_back_idle", bus.grant_cpu, 1'b0);
    chk("rd_idle_op", bus.op_host, 2'b00);
    // Host strobes still high in IDLE are ignored
    chk("idle_cpu_done", bus.cpu_done, 1'b0);
    chk("idle_fpu_done", bus.fpu_done, 1'b0);
    chk("idle_cpu_rdv", bus.cpu_rd_valid, 1'b0);
    chk("idle_fpu_rdv", bus.fpu_rd_valid, 1'b0);
    bus.tx_done_host = 1'b0; bus.rd_valid_host = 1'b0;

    // Reserved opcode plus a stray tx_done pulse in IDLE
    bus.cpu_op = 2'b11; bus.tx_done_host = 1'b1;
    tick();
    chk("rsv_grant_cpu", bus.grant_cpu, 1'b0);
    chk("rsv_grant_fpu", bus.grant_fpu, 1'b0);
    chk("rsv_op_host", bus.op_host, 2'b00);
    chk("rsv_cpu_done", bus.cpu_done, 1'b0);
    bus.tx_done_host = 1'b0;
    tick();
    chk("rsv_still_idle", bus.grant_cpu, 1'b0);
    bus.cpu_op = 2'b00;

    // FPU write of all-ones to 0x1000_0000
    bus.fpu_op = 2'b10; bus.fpu_addr = 32'h1000_0000; bus.fpu_wdata = ones;
    tick();
    chk("wr_grant_fpu", bus.grant_fpu, 1'b1);
    chk("wr_grant_cpu", bus.grant_cpu, 1'b0);
    chk("wr_op_host", bus.op_host, 2'b10);
    chk("wr_addr", bus.AddrOut_host, 32'h1000_0000);
    chk("wr_data", bus.DataOut_host, ones);
    bus.fpu_wdata = '0;
    tick();
    chk("wr_op_held", bus.op_host, 2'b10);
    chk("wr_data_held", bus.DataOut_host, ones);
    chk("wr_no_done", bus.fpu_done, 1'b0);
    bus.tx_done_host = 1'b1;
    settle();
    chk("wr_fpu_done", bus.fpu_done, 1'b1);
    chk("wr_cpu_done", bus.cpu_done, 1'b0);
    tick();
    bus.tx_done_host = 1'b0; bus.fpu_op = 2'b00;
    settle();
    chk("wr_done_1cyc", bus.fpu_done, 1'b0);
    chk("wr_back_idle", bus.grant_fpu, 1'b0);

    // Both request continuously; last grant so far was FPU
    bus.cpu_op = 2'b01; bus.cpu_addr = 32'h100;
    bus.fpu_op = 2'b01; bus.fpu_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_cpu = (i % 2 == 0);
`else
      exp_cpu = 1'b1;
`endif
      tick();
      chk($sformatf("tie%0d_grant_cpu", i), bus.grant_cpu, exp_cpu);
      chk($sformatf("tie%0d_grant_fpu", i), bus.grant_fpu, !exp_cpu);
      chk($sformatf("tie%0d_addr", i), bus.AddrOut_host, exp_cpu ? 32'h100 : 32'h200);
      bus.tx_done_host = 1'b1;
      tick();
      bus.tx_done_host = 1'b0;
      settle();
      chk($sformatf("tie%0d_idle_gap", i), bus.grant_cpu | bus.grant_fpu, 1'b0);
    end
    bus.cpu_op = 2'b00; bus.fpu_op = 2'b00;
    tick();

    // Reset in the middle of an FPU grant
    bus.fpu_op = 2'b10; bus.fpu_addr = 32'h300; bus.fpu_wdata = ones;
    tick();
    chk("rm_grant_fpu", bus.grant_fpu, 1'b1);
    rst = 1'b1; bus.tx_done_host = 1'b1;
    settle();
    chk("rm_no_fpu_done", bus.fpu_done, 1'b0);
    tick();
    rst = 1'b0; bus.tx_done_host = 1'b0;
    settle();
    chk("rm_idle_grant", bus.grant_fpu, 1'b0);
    chk("rm_idle_op", bus.op_host, 2'b00);
    chk("rm_addr_clr", bus.AddrOut_host, '0);
    chk("rm_fpu_done", bus.fpu_done, 1'b0);
    bus.cpu_op = 2'b01; bus.cpu_addr = 32'h400;
    tick();
    chk("rm_tie_cpu", bus.grant_cpu, 1'b1);
    chk("rm_tie_fpu", bus.grant_fpu, 1'b0);
    chk("rm_tie_addr", bus.AddrOut_host, 32'h400);
    bus.tx_done_host = 1'b1;
    tick();
    bus.tx_done_host = 1'b0; bus.cpu_op = 2'b00; bus.fpu_op = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
